pp_accum_seq: RTL

//  Sequential consumer of the 6x6 partial-product matrix: accepts one full matrix
//  (row i = x[5:0] & {6{y[i]}}) over a valid/ready handshake and reduces it one
//  row per clock into the 2*WIDTH-bit product. Sits directly downstream of the

---
 rtl/pp_accum_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/pp_accum_seq.sv
// Row-serial reducer for a WIDTH x WIDTH partial-product matrix (valid/ready in and out).
// Build option APPROX_LSB_EN: OR-compress the low APPROX_COLS product columns.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for a matrix, pp_ready=1
// S_ACC  | adding one latched row per clock, row 0 first
// S_DONE | product presented, held until prod_ready
module pp_accum_seq #(
  parameter int WIDTH       = 6,
  parameter int APPROX_COLS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH*WIDTH-1:0]   pp_i,
  input  logic                     pp_valid,
  output logic                     pp_ready,
  output logic [2*WIDTH-1:0]       prod_o,
  output logic                     prod_valid,
  input  logic                     prod_ready,
  output logic                     busy
);

  localparam int PW = 2 * WIDTH;
  localparam int RW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [WIDTH*WIDTH-1:0]   mat_q;
  logic [PW-1:0]            acc_q;
  logic [PW-1:0]            prod_q;
  logic [RW-1:0]            row_q;
  logic [WIDTH-1:0]         row_bits;
  logic [PW-1:0]            row_shift;
  logic [PW-1:0]            acc_sum;
  logic                     last_row;

  assign row_bits  = mat_q[WIDTH*int'(row_q) +: WIDTH];
  assign row_shift = {{WIDTH{1'b0}}, row_bits} << row_q;
  assign last_row  = (row_q == RW'(WIDTH - 1));

`ifdef APPROX_LSB_EN
  // Low columns never carry into the upper field.
  assign acc_sum = {acc_q[PW-1:APPROX_COLS] + row_shift[PW-1:APPROX_COLS],
                    acc_q[APPROX_COLS-1:0] | row_shift[APPROX_COLS-1:0]};
`else
  assign acc_sum = acc_q + row_shift;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pp_valid)   state_d = S_ACC;
      S_ACC:  if (last_row)   state_d = S_DONE;
      S_DONE: if (prod_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mat_q   <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (pp_valid) begin
            mat_q <= pp_i;
            acc_q <= '0;
            row_q <= '0;
          end
        end
        S_ACC: begin
          acc_q <= acc_sum;
          if (last_row) begin
            prod_q <= acc_sum;
            row_q  <= '0;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs depend on state only, so no path from prod_ready to pp_ready.
  assign pp_ready   = (state_q == S_IDLE);
  assign prod_valid = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign prod_o     = prod_q;

endmodule
